// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the divider controller: widths, op and state encodings.
package div_ctrl_pkg;

  localparam int unsigned DIV_CYCLES = 34;
  localparam int unsigned DATA_W     = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_MOD  = 2'd1,
    OP_DIVU = 2'd2,
    OP_MODU = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  // Remainder ops return the low half of the core result.
  function automatic logic op_is_rem(input op_t op);
    return (op == OP_MOD) || (op == OP_MODU);
  endfunction

endpackage

// File: rtl/div_ctrl.sv
// Divider controller: accepts a request from EX, issues it to the external
// signed/unsigned divider core, waits for the result and hands it back.
// Handles pipeline flush in every phase and a latency watchdog.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned DIV_LAT = DIV_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [DATA_W-1:0]   req_dividend,
  input  logic [DATA_W-1:0]   req_divisor,
  input  logic                flush,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_data,
  output logic                busy,
  output logic                core_s_tvalid,
  input  logic                core_s_tready,
  output logic                core_signed,
  output logic [DATA_W-1:0]   core_dividend,
  output logic [DATA_W-1:0]   core_divisor,
  input  logic                core_dout_tvalid,
  input  logic [2*DATA_W-1:0] core_dout_tdata,
  output logic                lat_err
);

  localparam int unsigned CNT_W = $clog2(DIV_LAT + 1);

  state_t           state;
  state_t           state_nxt;
  op_t              op_q;
  logic [CNT_W-1:0] lat_cnt;
  logic             flush_seen;
  logic             accept;
  logic             issue_hs;
  logic             capture;
  logic             lat_hit;

  // Handshake and status decodes, all derived from the state register.
  assign req_ready     = (state == ST_IDLE) && !flush;
  assign resp_valid    = (state == ST_DONE) && !flush;
  assign busy          = (state != ST_IDLE);
  assign core_s_tvalid = (state == ST_ISSUE);
  assign accept        = req_valid && req_ready;
  assign issue_hs      = (state == ST_ISSUE) && core_s_tready;
  assign capture       = (state == ST_WAIT) && core_dout_tvalid && !flush;
  assign lat_hit       = (lat_cnt == CNT_W'(DIV_LAT - 1)) || (lat_cnt == CNT_W'(DIV_LAT));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        // Once offered, the operation must complete on the core even if flushed.
        if (core_s_tready) state_nxt = (flush_seen || flush) ? ST_DRAIN : ST_WAIT;
      end
      ST_WAIT: begin
        if (core_dout_tvalid) state_nxt = flush ? ST_IDLE : ST_DONE;
        else if (flush)       state_nxt = ST_DRAIN;
      end
      ST_DONE: begin
        if (flush || resp_ready) state_nxt = ST_IDLE;
      end
      ST_DRAIN: begin
        if (core_dout_tvalid) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand, op and core select capture on request acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q          <= OP_DIV;
      core_signed   <= 1'b0;
      core_dividend <= '0;
      core_divisor  <= '0;
    end else if (accept) begin
      op_q          <= op_t'(req_op);
      core_signed   <= !req_op[1];
      core_dividend <= req_dividend;
      core_divisor  <= req_divisor;
    end
  end

  // Remember a flush seen while the core has not yet taken the operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 flush_seen <= 1'b0;
    else if (state != ST_ISSUE || issue_hs)  flush_seen <= 1'b0;
    else if (flush)                          flush_seen <= 1'b1;
  end

  // Latency counter: cleared on issue, counts and saturates while waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                   lat_cnt <= '0;
    else if (issue_hs)                                         lat_cnt <= '0;
    else if (state == ST_WAIT && lat_cnt != CNT_W'(DIV_LAT))   lat_cnt <= lat_cnt + CNT_W'(1);
  end

  // Sticky watchdog flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                               lat_err <= 1'b0;
    else if (state == ST_WAIT && !core_dout_tvalid && lat_hit) lat_err <= 1'b1;
  end

  // Result capture; holds until the next capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          resp_data <= '0;
    else if (capture) resp_data <= op_is_rem(op_q) ? core_dout_tdata[DATA_W-1:0]
                                                   : core_dout_tdata[2*DATA_W-1:DATA_W];
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed testbench for div_ctrl: table of divide vectors plus hand-written
// flush, watchdog and reset sequences. The bench plays the divider core.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_dividend;
  logic [31:0] req_divisor;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        busy;
  logic        core_s_tvalid;
  logic        core_s_tready;
  logic        core_signed;
  logic [31:0] core_dividend;
  logic [31:0] core_divisor;
  logic        core_dout_tvalid;
  logic [63:0] core_dout_tdata;
  logic        lat_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_op           (req_op),
    .req_dividend     (req_dividend),
    .req_divisor      (req_divisor),
    .flush            (flush),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_data        (resp_data),
    .busy             (busy),
    .core_s_tvalid    (core_s_tvalid),
    .core_s_tready    (core_s_tready),
    .core_signed      (core_signed),
    .core_dividend    (core_dividend),
    .core_divisor     (core_divisor),
    .core_dout_tvalid (core_dout_tvalid),
    .core_dout_tdata  (core_dout_tdata),
    .lat_err          (lat_err)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;    // quotient the core model returns
    logic [31:0] r;    // remainder the core model returns
    int          lat;  // cycles from issue handshake to core_dout_tvalid
    int          hold; // cycles resp_ready stays low in DONE
    logic [31:0] exp;
    logic        sgn;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request in IDLE; the next step lands in ISSUE.
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid    = 1'b1;
    req_op       = op;
    req_dividend = a;
    req_divisor  = b;
    step();
    req_valid    = 1'b0;
    req_dividend = '0;
    req_divisor  = '0;
  endtask

  task automatic core_pulse(input logic [63:0] data);
    core_dout_tvalid = 1'b1;
    core_dout_tdata  = data;
    step();
    core_dout_tvalid = 1'b0;
    core_dout_tdata  = '0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    chk($sformatf("v%0d_idle_ready", idx), 64'(req_ready), 64'd1);
    core_s_tready = 1'b1;
    send(v.op, v.a, v.b);
    // cycle 1: ISSUE, operands held by the controller
    chk($sformatf("v%0d_issue_tvalid", idx), 64'(core_s_tvalid), 64'd1);
    chk($sformatf("v%0d_issue_signed", idx), 64'(core_signed), 64'(v.sgn));
    chk($sformatf("v%0d_issue_dividend", idx), 64'(core_dividend), 64'(v.a));
    chk($sformatf("v%0d_issue_divisor", idx), 64'(core_divisor), 64'(v.b));
    chk($sformatf("v%0d_issue_busy", idx), 64'(busy), 64'd1);
    step();
    // cycle 2: first WAIT cycle; core answers in cycle 1+lat
    repeat (v.lat - 1) step();
    chk($sformatf("v%0d_wait_no_resp", idx), 64'(resp_valid), 64'd0);
    core_pulse({v.q, v.r});
    // cycle lat+2: DONE
    chk($sformatf("v%0d_resp_valid", idx), 64'(resp_valid), 64'd1);
    chk($sformatf("v%0d_resp_data", idx), 64'(resp_data), 64'(v.exp));
    for (int i = 0; i < v.hold; i++) begin
      step();
      chk($sformatf("v%0d_hold_valid", idx), 64'(resp_valid), 64'd1);
      chk($sformatf("v%0d_hold_data", idx), 64'(resp_data), 64'(v.exp));
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk($sformatf("v%0d_post_busy", idx), 64'(busy), 64'd0);
    chk($sformatf("v%0d_post_valid", idx), 64'(resp_valid), 64'd0);
    chk($sformatf("v%0d_post_ready", idx), 64'(req_ready), 64'd1);
    chk($sformatf("v%0d_post_data", idx), 64'(resp_data), 64'(v.exp));
  endtask

  initial begin
    //          op     dividend      divisor       quotient      remainder     lat hold expected      signed
    vecs[0] = '{2'd0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 20, 0, 32'hFFFFFFFD, 1'b1};
    vecs[1] = '{2'd3, 32'd100,      32'd7,        32'd14,       32'd2,         5, 5, 32'd2,        1'b0};
    vecs[2] = '{2'd2, 32'd100,      32'd7,        32'd14,       32'd2,         1, 0, 32'd14,       1'b0};
    vecs[3] = '{2'd1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF,  3, 1, 32'hFFFFFFFF, 1'b1};
    vecs[4] = '{2'd2, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        34, 0, 32'hFFFFFFFF, 1'b0};
    vecs[5] = '{2'd0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,         7, 0, 32'h80000000, 1'b1};

    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_dividend = '0; req_divisor = '0;
    flush = 1'b0; resp_ready = 1'b0; core_s_tready = 1'b1;
    core_dout_tvalid = 1'b0; core_dout_tdata = '0;
    repeat (2) step();
    rst = 1'b0;
    step();

    // Reset state
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_tvalid", 64'(core_s_tvalid), 64'd0);
    chk("rst_signed", 64'(core_signed), 64'd0);
    chk("rst_lat_err", 64'(lat_err), 64'd0);
    chk("rst_resp_data", 64'(resp_data), 64'd0);
    chk("rst_dividend", 64'(core_dividend), 64'd0);

    // Stray core result after reset is ignored in IDLE
    core_pulse(64'hDEADBEEF_CAFEF00D);
    chk("stray_busy", 64'(busy), 64'd0);
    chk("stray_valid", 64'(resp_valid), 64'd0);
    chk("stray_data", 64'(resp_data), 64'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);
    chk("vec_lat_err", 64'(lat_err), 64'd0);

    // Flush in the third WAIT cycle -> DRAIN, result discarded
    send(2'd2, 32'd100, 32'd7);
    step();                    // cycle 2, WAIT
    step(); step();            // cycle 4
    flush = 1'b1;
    chk("wflush_ready_masked", 64'(req_ready), 64'd0);
    step();
    flush = 1'b0;
    chk("wflush_drain_busy", 64'(busy), 64'd1);
    chk("wflush_drain_valid", 64'(resp_valid), 64'd0);
    flush = 1'b1;              // no effect in DRAIN
    step();
    flush = 1'b0;
    chk("wflush_drain_flush_busy", 64'(busy), 64'd1);
    core_pulse(64'h11111111_22222222);
    chk("wflush_ready", 64'(req_ready), 64'd1);
    chk("wflush_valid", 64'(resp_valid), 64'd0);
    chk("wflush_data_kept", 64'(resp_data), 64'h80000000);

    // Flush during ISSUE with tready low for 4 cycles
    core_s_tready = 1'b0;
    send(2'd1, 32'h12345678, 32'd9);
    flush = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("iflush_tvalid_%0d", i), 64'(core_s_tvalid), 64'd1);
      chk($sformatf("iflush_dividend_%0d", i), 64'(core_dividend), 64'h12345678);
      chk($sformatf("iflush_divisor_%0d", i), 64'(core_divisor), 64'd9);
      step();
      flush = 1'b0;
    end
    core_s_tready = 1'b1;
    chk("iflush_tvalid_last", 64'(core_s_tvalid), 64'd1);
    step();
    chk("iflush_drain_tvalid", 64'(core_s_tvalid), 64'd0);
    chk("iflush_drain_busy", 64'(busy), 64'd1);
    chk("iflush_drain_valid", 64'(resp_valid), 64'd0);
    core_pulse(64'h00000000_55555555);
    chk("iflush_ready", 64'(req_ready), 64'd1);
    chk("iflush_valid", 64'(resp_valid), 64'd0);

    // Flush together with core result in WAIT -> IDLE, discarded
    send(2'd3, 32'd50, 32'd8);
    step();
    step();
    flush = 1'b1;
    core_pulse(64'h00000006_00000002);
    flush = 1'b0;
    chk("wtflush_busy", 64'(busy), 64'd0);
    chk("wtflush_valid", 64'(resp_valid), 64'd0);
    chk("wtflush_data_kept", 64'(resp_data), 64'h80000000);

    // Flush in DONE drops the response
    send(2'd3, 32'd50, 32'd8);
    step();
    step();
    core_pulse(64'h00000006_00000002);
    chk("dflush_valid_pre", 64'(resp_valid), 64'd1);
    flush = 1'b1;
    #1;
    chk("dflush_valid_masked", 64'(resp_valid), 64'd0);
    step();
    flush = 1'b0;
    chk("dflush_busy", 64'(busy), 64'd0);
    chk("dflush_valid", 64'(resp_valid), 64'd0);
    chk("dflush_data", 64'(resp_data), 64'd2);

    // Latency watchdog: no core response
    send(2'd0, 32'd1000, 32'd3);
    step();                    // cycle 2, 0 WAIT edges elapsed
    repeat (33) step();        // cycle 35, 33 edges after issue handshake
    chk("wd_not_yet", 64'(lat_err), 64'd0);
    step();                    // 34 edges after issue handshake
    chk("wd_set", 64'(lat_err), 64'd1);
    repeat (5) step();
    chk("wd_still_wait", 64'(busy), 64'd1);
    chk("wd_no_resp", 64'(resp_valid), 64'd0);
    core_pulse(64'h0000014D_00000001);
    chk("wd_late_valid", 64'(resp_valid), 64'd1);
    chk("wd_late_data", 64'(resp_data), 64'h14D);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("wd_sticky", 64'(lat_err), 64'd1);
    chk("wd_idle", 64'(busy), 64'd0);

    // Asynchronous reset in WAIT
    send(2'd0, 32'd77, 32'd7);
    step();
    step();
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_tvalid", 64'(core_s_tvalid), 64'd0);
    chk("arst_resp_valid", 64'(resp_valid), 64'd0);
    chk("arst_lat_err", 64'(lat_err), 64'd0);
    chk("arst_resp_data", 64'(resp_data), 64'd0);
    chk("arst_signed", 64'(core_signed), 64'd0);
    chk("arst_dividend", 64'(core_dividend), 64'd0);
    step();
    rst = 1'b0;
    step();
    core_pulse(64'h0000000B_00000000);
    chk("arst_late_valid", 64'(resp_valid), 64'd0);
    chk("arst_late_busy", 64'(busy), 64'd0);
    chk("arst_late_ready", 64'(req_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameter DIV_LAT, default `DIV_CYCLES; maximum core latency in cycles, counted from the input handshake to core_dout_tvalid.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  EX stage presents a divide request.
REQ-005 req_ready  output  1  controller accepts a request.
REQ-006 req_op  input  2  0=DIV, 1=MOD, 2=DIVU, 3=MODU.
REQ-007 req_dividend / req_divisor  input  32 each  operands.
REQ-008 flush  input  1  pipeline flush; cancels the current operation.
REQ-009 resp_valid  output  1  result available.
REQ-010 resp_ready  input  1  consumer takes the result.
REQ-011 resp_data  output  32  selected quotient or remainder.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 core_s_tvalid  output  1  drives both the dividend and divisor tvalid of the core.
REQ-014 core_s_tready  input  1  AND of the core dividend and divisor tready.
REQ-015 core_signed  output  1  selects the signed core; 0 selects the unsigned core.
REQ-016 core_dividend / core_divisor  output  32 each  registered operands.
REQ-017 core_dout_tvalid  input  1  result valid from the selected core.
REQ-018 core_dout_tdata  input  64  quotient in [63:32], remainder in [31:0].
REQ-019 lat_err  output  1  sticky flag: latency watchdog expired.

Function
REQ-020 The controller SHALL implement the states IDLE, ISSUE, WAIT, DONE and DRAIN.
REQ-021 req_ready SHALL equal (state==IDLE && !flush).
REQ-022 On req_valid&&req_ready the controller SHALL register the operands, op and core_signed=!req_op[1], then go to ISSUE.
REQ-023 In ISSUE, core_s_tvalid SHALL be 1 and SHALL stay 1 with stable data until core_s_tready=1, including when flush is asserted.
REQ-024 On the ISSUE handshake the controller SHALL clear the latency counter and go to WAIT, or to DRAIN if a flush was latched during ISSUE or is present that cycle.
REQ-025 In WAIT the latency counter SHALL increment every cycle and saturate at DIV_LAT.
REQ-026 In WAIT, if core_dout_tvalid=1 and flush=0, resp_data SHALL capture tdata[63:32] for DIV/DIVU or tdata[31:0] for MOD/MODU, and the state SHALL go to DONE.
REQ-027 In WAIT, flush with core_dout_tvalid=0 SHALL go to DRAIN.
REQ-028 In WAIT, flush together with core_dout_tvalid=1 SHALL go to IDLE and discard the result.
REQ-029 In DRAIN the controller SHALL discard results and return to IDLE on core_dout_tvalid; flush in DRAIN SHALL have no effect.
REQ-030 In DONE, resp_valid SHALL equal !flush; resp_valid&&resp_ready SHALL go to IDLE; flush SHALL go to IDLE and discard the result.
REQ-031 resp_data SHALL hold its value until the next capture.
REQ-032 If the latency counter reaches DIV_LAT in WAIT without core_dout_tvalid, lat_err SHALL be set, held until reset, and the state SHALL stay WAIT.
REQ-033 Minimum latency: accept at cycle 0, ISSUE at cycle 1, resp_valid at cycle N+2 when core_dout_tvalid arrives N cycles after the ISSUE handshake (tready=1 at cycle 1).
REQ-034 There SHALL be no back-to-back issue: the next request is accepted no earlier than the cycle after the response handshake.
REQ-035 Divide-by-zero and signed overflow SHALL return the core output unmodified.

Reset
REQ-036 On rst the state SHALL be IDLE, all registers and lat_err 0, and resp_valid, core_s_tvalid, busy and core_signed 0; this holds also mid-operation.
REQ-037 After reset is released, the first core_dout_tvalid SHALL be ignored if the core was reset independently, i.e. treated as in IDLE with no state change.

Structure
REQ-038 The op encodings, state encodings and DIV_CYCLES SHALL live in the shared defs header.
REQ-039 No sub-module is required; the signed and unsigned divider cores SHALL be instantiated by the parent and muxed by core_signed.

Verification
REQ-040 DIV with dividend=-7 (0xFFFFFFF9), divisor=2, core latency 20, tready=1 -> resp_valid at cycle 22 with resp_data=0xFFFFFFFD; busy low one cycle after the response handshake.
REQ-041 MODU with 100, 7 and resp_ready held low for 5 cycles -> resp_valid and resp_data=2 held stable for 5 cycles, then IDLE.
REQ-042 flush 3 cycles into WAIT -> DRAIN, result discarded, resp_valid stays 0, req_ready=1 one cycle after core_dout_tvalid.
REQ-043 flush during ISSUE with tready low for 4 cycles -> core_s_tvalid and operands held 4 cycles, then DRAIN, no response.
REQ-044 core never asserts core_dout_tvalid, DIV_LAT=34 -> lat_err=1 34 cycles after the ISSUE handshake and stays 1 until rst.
REQ-045 rst asserted in WAIT -> all outputs 0 asynchronously; a later core_dout_tvalid produces no resp_valid.
